// File: rtl/aes_roundkey_store_256_pkg.sv
// aes_pkg: shared AES-256 constants, round-key type and key-store FSM states.
package aes_pkg;
    localparam int AES256_NR    = 14;
    localparam int AES256_NK_RK = AES256_NR + 1;
    localparam int AES_KW       = 128;
    localparam int AES_IW       = 4;
    typedef logic [AES_KW-1:0] rk_t;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} rks_state_t;
endpackage

// File: rtl/aes_roundkey_store_256_if.sv
// aes_roundkey_store_256_if: key-stream capture and round-key read bus.
interface aes_roundkey_store_256_if;
    import aes_pkg::*;
    logic              load_start;
    rk_t               ke_subkey;
    logic              ke_rdy;
    logic              busy;
    logic              keys_valid;
    logic              load_err;
    logic              rd_en;
    logic [AES_IW-1:0] rd_round;
    logic              rd_decrypt;
    rk_t               rd_key;
    logic              rd_valid;
    logic              rd_err;
    modport master (output load_start, ke_subkey, ke_rdy, rd_en, rd_round, rd_decrypt,
                    input  busy, keys_valid, load_err, rd_key, rd_valid, rd_err);
    modport slave  (input  load_start, ke_subkey, ke_rdy, rd_en, rd_round, rd_decrypt,
                    output busy, keys_valid, load_err, rd_key, rd_valid, rd_err);
endinterface

// File: rtl/aes_roundkey_store_256_rk_regfile.sv
// rk_regfile: NK x KW round-key storage, one sync write port, one registered
// read port that returns zero with an error flag for bad or unqualified reads.
module rk_regfile #(
    parameter int NK = 15,
    parameter int KW = 128,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [KW-1:0] wdata_i,
    input  logic          re_i,
    input  logic          rok_i,
    input  logic [AW-1:0] raddr_i,
    output logic [KW-1:0] rdata_o,
    output logic          rvalid_o,
    output logic          rerr_o
);
    logic [KW-1:0] mem_q [NK];
    logic          bad_d;
    assign bad_d = (raddr_i >= AW'(NK)) || !rok_i;
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            rerr_o   <= 1'b0;
        end else begin
            rvalid_o <= re_i;
            rerr_o   <= re_i && bad_d;
            if (re_i) rdata_o <= bad_d ? '0 : mem_q[raddr_i];
        end
endmodule

// File: rtl/aes_roundkey_store_256.sv
// aes_roundkey_store_256: captures the 15 AES-256 round keys from the expansion
// stage and serves them by round in forward or reversed order.
module aes_roundkey_store_256 import aes_pkg::*; #(
    parameter int NK = AES256_NK_RK,
    parameter int KW = AES_KW,
    parameter int IW = AES_IW
) (
    input logic                     clk,
    input logic                     reset,
    aes_roundkey_store_256_if.slave bus
);
    rks_state_t    state_q;
    logic [IW-1:0] cnt_q;
    logic          busy_q, keys_valid_q, load_err_q;
    logic          we_d;
    logic [IW-1:0] waddr_d, raddr_d;
    // Key 0 arrives with the start pulse itself, so the start cycle writes slot 0.
    assign we_d    = (state_q == LOAD) ? bus.ke_rdy : bus.load_start;
    assign waddr_d = (state_q == LOAD) ? cnt_q : '0;
    assign raddr_d = bus.rd_decrypt ? IW'(NK-1) - bus.rd_round : bus.rd_round;
    assign bus.busy       = busy_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.load_err   = load_err_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            load_err_q <= 1'b0;
            if (state_q == LOAD) begin
                if (!bus.ke_rdy) begin
                    load_err_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end else if (cnt_q == IW'(NK-1)) begin
                    keys_valid_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= DONE;
                end else
                    cnt_q <= cnt_q + 1'b1;
            end else if (bus.load_start) begin
                cnt_q        <= IW'(1);
                keys_valid_q <= 1'b0;
                busy_q       <= 1'b1;
                state_q      <= LOAD;
            end
        end
    rk_regfile #(.NK(NK), .KW(KW), .AW(IW)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .we_i     (we_d),
        .waddr_i  (waddr_d),
        .wdata_i  (bus.ke_subkey),
        .re_i     (bus.rd_en),
        .rok_i    (keys_valid_q),
        .raddr_i  (raddr_d),
        .rdata_o  (bus.rd_key),
        .rvalid_o (bus.rd_valid),
        .rerr_o   (bus.rd_err)
    );
endmodule

// File: tb/tb_aes_roundkey_store_256.sv
// tb_aes_roundkey_store_256: drives AES-256 key schedules from a behavioural
// expansion model and checks captures and reads against a key-store model.
module tb_aes_roundkey_store_256;
    import aes_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    aes_roundkey_store_256_if bus();
    aes_roundkey_store_256 dut (.clk(clk), .reset(reset), .bus(bus.slave));
    int tests = 0;
    int fails = 0;
    rk_t sched [15];
    rk_t stored [15];
    bit  mvalid = 1'b0;
    localparam rk_t FIPS_R0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam rk_t FIPS_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v = 8'h01;
        repeat (254) v = gmul(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (i % 8 == 4) t = subword(t);
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input int r, input bit dec);
        bit  ee = (r > 14) || !mvalid;
        rk_t ek = ee ? '0 : stored[dec ? 14 - r : r];
        bus.rd_en = 1'b1;
        bus.rd_round = 4'(r);
        bus.rd_decrypt = dec;
        step();
        bus.rd_en = 1'b0;
        chk($sformatf("rd_valid r%0d d%0d", r, dec), 128'(bus.rd_valid), 128'd1);
        chk($sformatf("rd_err r%0d d%0d", r, dec), 128'(bus.rd_err), 128'(ee));
        chk($sformatf("rd_key r%0d d%0d", r, dec), bus.rd_key, ek);
        step();
        chk("rd_valid_drop", 128'(bus.rd_valid), 128'd0);
        chk("rd_err_drop", 128'(bus.rd_err), 128'd0);
        chk("rd_key_hold", bus.rd_key, ek);
    endtask

    task automatic load(input logic [255:0] key, input int n, input int restart_at,
                        input int reset_at, input bit rd_same);
        int  rr = $urandom_range(0, 14);
        bit  oe = !mvalid;
        rk_t ok = oe ? '0 : stored[rr];
        expand(key);
        bus.load_start = 1'b1;
        bus.ke_subkey = sched[0];
        bus.ke_rdy = 1'b0;
        bus.rd_en = rd_same;
        bus.rd_round = 4'(rr);
        bus.rd_decrypt = 1'b0;
        step();
        bus.load_start = 1'b0;
        bus.rd_en = 1'b0;
        mvalid = 1'b0;
        if (rd_same) begin
            chk("same_cycle_err", 128'(bus.rd_err), 128'(oe));
            chk("same_cycle_key", bus.rd_key, ok);
        end
        chk("start_kv_fall", 128'(bus.keys_valid), 128'd0);
        for (int k = 1; k < n; k++) begin
            if (k == reset_at) begin
                reset = 1'b0;
                #1;
                chk("rst_busy", 128'(bus.busy), 128'd0);
                chk("rst_kv", 128'(bus.keys_valid), 128'd0);
                chk("rst_load_err", 128'(bus.load_err), 128'd0);
                chk("rst_rd_valid", 128'(bus.rd_valid), 128'd0);
                chk("rst_rd_err", 128'(bus.rd_err), 128'd0);
                chk("rst_rd_key", bus.rd_key, 128'd0);
                bus.ke_rdy = 1'b0;
                step();
                reset = 1'b1;
                return;
            end
            bus.ke_rdy = 1'b1;
            bus.ke_subkey = sched[k];
            bus.load_start = (k == restart_at);
            chk($sformatf("load_busy k%0d", k), 128'(bus.busy), 128'd1);
            chk($sformatf("load_kv k%0d", k), 128'(bus.keys_valid), 128'd0);
            step();
        end
        bus.ke_rdy = 1'b0;
        bus.load_start = 1'b0;
        if (n == 15) begin
            chk("done_kv", 128'(bus.keys_valid), 128'd1);
            chk("done_busy", 128'(bus.busy), 128'd0);
            stored = sched;
            mvalid = 1'b1;
        end else begin
            step();
            chk("trunc_load_err", 128'(bus.load_err), 128'd1);
            chk("trunc_busy", 128'(bus.busy), 128'd0);
            chk("trunc_kv", 128'(bus.keys_valid), 128'd0);
            step();
            chk("trunc_err_pulse", 128'(bus.load_err), 128'd0);
        end
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        bus.load_start = 1'b0;
        bus.ke_subkey = '0;
        bus.ke_rdy = 1'b0;
        bus.rd_en = 1'b0;
        bus.rd_round = '0;
        bus.rd_decrypt = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 128'(bus.busy), 128'd0);
        chk("reset_kv", 128'(bus.keys_valid), 128'd0);
        chk("reset_load_err", 128'(bus.load_err), 128'd0);
        chk("reset_rd_valid", 128'(bus.rd_valid), 128'd0);
        chk("reset_rd_err", 128'(bus.rd_err), 128'd0);
        chk("reset_rd_key", bus.rd_key, 128'd0);
        @(negedge clk);
        reset = 1'b1;
        rd(0, 0);
        rd(15, 0);
        load(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 15, -1, -1, 0);
        rd(0, 0);  chk("fips_fwd_r0", bus.rd_key, FIPS_R0);
        rd(14, 0); chk("fips_fwd_r14", bus.rd_key, FIPS_R14);
        rd(0, 1);  chk("fips_dec_r0", bus.rd_key, FIPS_R14);
        rd(14, 1); chk("fips_dec_r14", bus.rd_key, FIPS_R0);
        rd(15, 0);
        rd(15, 1);
        load(rand_key(), 6, -1, -1, 0);
        rd(0, 0);
        rd(7, 1);
        load(rand_key(), 15, -1, -1, 0);
        for (int i = 0; i < 20; i++) rd($urandom_range(0, 15), 1'($urandom));
        load(rand_key(), 15, -1, 8, 0);
        rd(3, 0);
        load(rand_key(), 15, 5, -1, 0);
        for (int r = 0; r < 15; r++) rd(r, 0);
        load({256{1'b1}}, 15, -1, -1, 1);
        rd(0, 0);
        chk("reload_ff_r0", bus.rd_key, {128{1'b1}});
        for (int i = 0; i < 30; i++) rd($urandom_range(0, 15), 1'($urandom));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
